// File: rtl/pulse_peak_binner.sv
// pulse_peak_binner: threshold pulse detector that emits one histogram increment per pulse at its peak bin.
module pulse_peak_binner #(
    parameter int ADC_W   = 12,
    parameter int AW      = 8,
    parameter int HOLDOFF = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acq_en,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample,
    input  logic [ADC_W-1:0] threshold,
    input  logic [AW-1:0]    host_addr,
    output logic [AW-1:0]    hist_addr,
    output logic             hist_rw,
    output logic [31:0]      event_count,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, TRACK, EMIT, HOLD} state_t;
    localparam int CW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
    state_t           state_q, state_d;
    logic [ADC_W-1:0] peak_q, peak_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic             rw_q, rw_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      event_count_q, event_count_d;
    logic             above, emit;
    assign above = sample >= threshold;
    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (acq_en && sample_valid && above) begin
                    state_d = TRACK;
                    peak_d  = sample;
                end
            end
            TRACK: begin
                if (!acq_en) state_d = IDLE;
                else if (sample_valid && !above) state_d = EMIT;
                else if (sample_valid && sample > peak_q) peak_d = sample;
            end
            EMIT: begin
                state_d = HOLDOFF > 0 ? HOLD : IDLE;
                hold_d  = CW'(HOLDOFF - 1);
            end
            HOLD: begin
                if (hold_q == '0) state_d = IDLE;
                else hold_d = hold_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered on the edge entering EMIT so the increment is visible during EMIT
        emit          = state_q == TRACK && state_d == EMIT;
        rw_d          = !emit;
        addr_d        = emit ? peak_q[ADC_W-1 -: AW] : host_addr;
        event_count_d = emit && !(&event_count_q) ? event_count_q + 32'd1 : event_count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            peak_q        <= '0;
            hold_q        <= '0;
            rw_q          <= 1'b1;
            addr_q        <= '0;
            event_count_q <= '0;
        end else begin
            state_q       <= state_d;
            peak_q        <= peak_d;
            hold_q        <= hold_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            event_count_q <= event_count_d;
        end
    end
    assign hist_addr   = addr_q;
    assign hist_rw     = rw_q;
    assign event_count = event_count_q;
    assign busy        = state_q != IDLE;
endmodule

// File: doc/pulse_peak_binner.md
Name: pulse_peak_binner

Overview:
Upstream stage of the histogram memory. It takes the ADC sample stream, detects threshold-crossing pulses, and tracks each pulse's peak amplitude. At pulse end it issues exactly one single-cycle increment to the histogram at the bin for that peak. When not producing an increment, it forwards the host read address with read mode asserted, so software can read back the spectrum through the same address port.

Parameters:
ADC_W, 12, sample width in bits
AW, 8, histogram address width; bin = top AW bits of peak (requires AW <= ADC_W)
HOLDOFF, 16, dead-time cycles after each emitted event (0 allowed)

Ports:
clk  input  1  global clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
acq_en  input  1  acquisition enable; 0 = read-only mode, no events emitted
sample_valid  input  1  qualifies sample for one cycle
sample  input  ADC_W  unsigned ADC sample
threshold  input  ADC_W  unsigned trigger level, compared live every cycle
host_addr  input  AW  bin address requested by host readout
hist_addr  output  AW  address to histogram memory, registered
hist_rw  output  1  to histogram: 1 = read, 0 = increment; registered
event_count  output  32  number of emitted events, saturating
busy  output  1  high in TRACK, EMIT, HOLDOFF

Behaviour:
- Reset, sampled on a clk edge with rst=1: state=IDLE, peak=0, holdoff counter=0, hist_rw=1, hist_addr=0, event_count=0, busy=0. Reset overrides all other inputs in the same cycle.
- Critical rule: the histogram increments on every clock where rw=0. hist_rw must therefore be 0 for exactly one cycle per accepted pulse, and never otherwise, including during reset or after reset.
- FSM states: IDLE, TRACK, EMIT, HOLDOFF. Each transition takes effect on the next clk edge.
  - IDLE:
    - If acq_en=1, sample_valid=1 and sample >= threshold: go to TRACK, peak <= sample.
    - Otherwise stay in IDLE.
    - Samples with sample_valid=0 are ignored in all states.
  - TRACK, on a valid sample:
    - If sample >= threshold: peak <= max(peak, sample), stay in TRACK.
    - If sample < threshold: go to EMIT; peak is frozen and the falling sample is not included.
    - If acq_en=0 in any cycle: go to IDLE with no emit (aborted pulse, not counted).
  - EMIT, one cycle only:
    - Registered outputs take effect on the edge entering EMIT, so hist_rw=0 and hist_addr=peak[ADC_W-1 -: AW] are visible during the EMIT cycle.
    - event_count <= event_count+1, saturating at 32'hFFFFFFFF.
    - Next state is HOLDOFF if HOLDOFF>0, else IDLE.
    - EMIT completes even if acq_en falls during it.
  - HOLDOFF:
    - The counter loads HOLDOFF-1 on entry and decrements each cycle; go to IDLE when it reaches 0 (exactly HOLDOFF cycles in the state).
    - All samples are ignored.
    - A sample above threshold when IDLE is re-entered starts a new pulse normally.
- Outside the EMIT cycle: hist_rw=1 and hist_addr <= host_addr (one-cycle registered path). Host address to histogram data_out latency is 2 clk edges.
- Bin mapping is truncation only, no rounding:
  - peak 0..(2^(ADC_W-AW))-1 -> bin 0
  - full scale 2^ADC_W-1 -> bin 2^AW-1
  - no overflow bin
- A pulse that stays above threshold indefinitely remains in TRACK with no emit and no timeout; busy stays 1.
- threshold=0: every valid sample is >= threshold, so no pulse ever ends; this is the required behaviour, documented as a misconfiguration.
- acq_en rising while in IDLE mid-pulse: a sample already above threshold triggers TRACK immediately (partial pulse accepted).

Test Plan:
- Reset: rst=1 for 3 cycles with sample=4095 and acq_en=1 -> hist_rw=1 every cycle, hist_addr=0, event_count=0, busy=0; hist_rw stays 1 on the first post-reset cycle.
- Single pulse, ADC_W=12, AW=8, threshold=100, valid samples 50,200,900,600,80 -> exactly one cycle with hist_rw=0, hist_addr=56 (900>>4), one cycle after the 80 sample; event_count=1; then busy for 16 cycles.
- Holdoff: second pulse 300,2000,10 starting 5 cycles after EMIT -> ignored, no rw=0, count stays 1. Same pulse starting 17+ cycles after EMIT -> hist_addr=125, count=2.
- Abort and gaps: pulse 500,700 then acq_en=0 -> no rw=0, count unchanged. Pulse with sample_valid gaps (200,-,-,4095,-,20) -> hist_addr=255.
- Host readout: acq_en=0, host_addr sweeps 0..255 -> hist_addr follows with 1-cycle delay and hist_rw constantly 1.
- Saturation: force event_count to 32'hFFFFFFFE, emit 3 pulses -> event_count ends at 32'hFFFFFFFF, and each pulse still produces its single rw=0 cycle.
